// File: rtl/pot_adc_pkg.sv
// pot_adc_pkg: shared constants, FSM state type and helpers for the pot ADC sampler
package pot_adc_pkg;
  localparam int ADC_BITS = 10;
  localparam int FRAME_BITS = 17;
  localparam int MISO_FIRST = 7;
  localparam int MOSI_CMD_BITS = 5;
  // half-period index of the last SCLK high phase, and of the final CS-hold phase
  localparam int LAST_HALF = 2 * FRAME_BITS;
  localparam int END_HALF = LAST_HALF + 2;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, ACCUM} state_t;
  function automatic logic [ADC_BITS-1:0] abs_diff(input logic [ADC_BITS-1:0] a, input logic [ADC_BITS-1:0] b);
    return a > b ? a - b : b - a;
  endfunction
endpackage

// File: rtl/pot_adc_sampler_if.sv
// pot_adc_sampler_if: SPI pins and filtered-output bundle of the pot ADC sampler
interface pot_adc_sampler_if;
  import pot_adc_pkg::*;
  logic adc_miso;
  logic adc_sclk;
  logic adc_mosi;
  logic adc_cs_n;
  logic [ADC_BITS-1:0] adc_out;
  logic adc_valid;
  logic busy;
  modport master (input adc_miso, output adc_sclk, adc_mosi, adc_cs_n, adc_out, adc_valid, busy);
  modport slave (output adc_miso, input adc_sclk, adc_mosi, adc_cs_n, adc_out, adc_valid, busy);
endinterface

// File: rtl/pot_adc_sampler_xfer.sv
// spi_adc_xfer: one MCP3008-style SPI frame (SCLK divider, half-period counter, shift register)
module spi_adc_xfer
  import pot_adc_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          channel,
  input  logic                miso,
  output logic                sclk,
  output logic                mosi,
  output logic                cs_n,
  output logic                half_end,
  output logic [5:0]          half,
  output logic                done,
  output logic [ADC_BITS-1:0] sample
);
  localparam int DW = $clog2(CLK_DIV);
  logic active_q, active_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0] half_q, half_d, k;
  logic [ADC_BITS-1:0] sr_q, sr_d;
  logic [7:0] cmd;
  // half 0 is CS setup, 1..34 alternate SCLK low/high for k=0..16, 35..36 hold CS low
  always_comb begin
    half_end = active_q && div_q == DW'(CLK_DIV - 1);
    done = half_end && half_q == 6'(END_HALF);
    k = half_q == 6'd0 ? 6'd0 : (half_q - 6'd1) >> 1;
    cmd = {3'b000, channel[0], channel[1], channel[2], 2'b11};
    sclk = active_q && !half_q[0] && half_q >= 6'd2 && half_q <= 6'(LAST_HALF);
    mosi = active_q && k < 6'(MOSI_CMD_BITS) && cmd[k[2:0]];
    cs_n = !active_q;
    active_d = start || (active_q && !done);
    div_d = start || half_end ? '0 : active_q ? div_q + DW'(1) : div_q;
    half_d = start ? '0 : half_end ? half_q + 6'd1 : half_q;
    sr_d = sclk && div_q == '0 && half_q >= 6'(2 * (MISO_FIRST + 1)) ? {sr_q[ADC_BITS-2:0], miso} : sr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      div_q <= '0;
      half_q <= '0;
      sr_q <= '0;
    end else begin
      active_q <= active_d;
      div_q <= div_d;
      half_q <= half_d;
      sr_q <= sr_d;
    end
  end
  assign half = half_q;
  assign sample = sr_q;
endmodule

// File: rtl/pot_adc_sampler.sv
// pot_adc_sampler: periodic pot ADC conversions, group averaging and hysteresis before publishing adc_out
module pot_adc_sampler
  import pot_adc_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int SAMPLE_PERIOD = 50000,
  parameter int CHANNEL = 0,
  parameter int AVG_LOG2 = 3,
  parameter int HYST = 2
) (
  input logic clk,
  input logic reset,
  pot_adc_sampler_if.master bus
);
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int AW = ADC_BITS + AVG_LOG2;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0] n_q, n_d;
  logic [ADC_BITS-1:0] out_q, out_d, avg, sample;
  logic valid_q, valid_d, first_q, first_d;
  logic start, half_end, done, last, upd;
  logic [5:0] half;
  spi_adc_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
    .clk(clk),
    .reset(reset),
    .start(start),
    .channel(3'(CHANNEL)),
    .miso(bus.adc_miso),
    .sclk(bus.adc_sclk),
    .mosi(bus.adc_mosi),
    .cs_n(bus.adc_cs_n),
    .half_end(half_end),
    .half(half),
    .done(done),
    .sample(sample)
  );
  always_comb begin
    timer_d = timer_q == TW'(SAMPLE_PERIOD - 1) ? '0 : timer_q + TW'(1);
    start = state_q == IDLE && timer_q == TW'(SAMPLE_PERIOD - 1);
    sum = acc_q + AW'(sample);
    avg = sum[AW-1:AVG_LOG2];
    last = n_q == '1;
    // endpoints bypass the dead band so 0 and full scale stay reachable
    upd = !first_q || abs_diff(avg, out_q) > ADC_BITS'(HYST) || ((avg == '0 || avg == '1) && avg != out_q);
    state_d = state_q;
    acc_d = acc_q;
    n_d = n_q;
    out_d = out_q;
    valid_d = 1'b0;
    first_d = first_q;
    case (state_q)
      IDLE:     state_d = start ? CS_SETUP : IDLE;
      CS_SETUP: state_d = half_end ? SHIFT : CS_SETUP;
      SHIFT:    state_d = half_end && half == 6'(LAST_HALF) ? CS_HOLD : SHIFT;
      CS_HOLD:  state_d = done ? ACCUM : CS_HOLD;
      default: begin
        state_d = IDLE;
        acc_d = last ? '0 : sum;
        n_d = n_q + AVG_LOG2'(1);
        out_d = last && upd ? avg : out_q;
        valid_d = last && upd;
        first_d = first_q || (last && upd);
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      acc_q <= '0;
      n_q <= '0;
      out_q <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      acc_q <= acc_d;
      n_q <= n_d;
      out_q <= out_d;
      valid_q <= valid_d;
      first_q <= first_d;
    end
  end
  assign bus.adc_out = out_q;
  assign bus.adc_valid = valid_q;
  assign bus.busy = state_q == CS_SETUP || state_q == SHIFT || state_q == CS_HOLD;
endmodule

// File: tb/tb_pot_adc_sampler.sv
// tb_pot_adc_sampler: behavioural ADC plus averaging/hysteresis reference checking pot_adc_sampler
module tb_pot_adc_sampler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pot_adc_sampler_if bus0 ();
  pot_adc_sampler_if bus1 ();
  pot_adc_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(200), .CHANNEL(0), .AVG_LOG2(2), .HYST(2)) u0 (
    .clk(clk), .reset(rst), .bus(bus0));
  pot_adc_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(200), .CHANNEL(5), .AVG_LOG2(2), .HYST(2)) u1 (
    .clk(clk), .reset(rst), .bus(bus1));

  logic miso0 = 1'b0;
  assign bus0.adc_miso = miso0;
  assign bus1.adc_miso = 1'b0;

  // ADC model: counts SCLK rises per frame, captures the command, returns B9..B0 after the null bit
  logic [9:0] next_vals[$];
  logic [9:0] cur_val = '0;
  logic [4:0] cmd0 = '0, cmd1 = '0;
  int k0 = 0, k1 = 0, frames0 = 0;
  always @(negedge bus0.adc_cs_n)
    if (next_vals.size() > 0) cur_val = next_vals.pop_front();
    else cur_val = '0;
  always @(posedge bus0.adc_sclk or posedge bus0.adc_cs_n)
    if (bus0.adc_cs_n) begin
      if (k0 == 17) frames0++;
      k0 = 0;
    end else begin
      if (k0 < 5) cmd0[k0] = bus0.adc_mosi;
      k0++;
    end
  always @(negedge bus0.adc_sclk) miso0 = (k0 >= 7 && k0 <= 16) ? cur_val[16 - k0] : 1'b0;
  always @(posedge bus1.adc_sclk or posedge bus1.adc_cs_n)
    if (bus1.adc_cs_n) k1 = 0;
    else begin
      if (k1 < 5) cmd1[k1] = bus1.adc_mosi;
      k1++;
    end

  // monitors: published values, strobe latency, out changes without strobe, CS low time, SCLK idle level
  int cyc = 0, rise_cyc = -10, lat_bad = 0, glitch = 0, idle_sclk = 0;
  int low0 = 0, len0 = 0, low1 = 0, len1 = 0;
  logic cs_prev = 1'b1;
  logic [9:0] out_prev = '0;
  logic [9:0] pub_q[$];
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus0.adc_cs_n && !cs_prev) rise_cyc = cyc;
      if (bus0.adc_valid) begin
        pub_q.push_back(bus0.adc_out);
        if (cyc - rise_cyc != 1) lat_bad++;
      end else if (bus0.adc_out !== out_prev) glitch++;
      if ((bus0.adc_cs_n && bus0.adc_sclk) || (bus1.adc_cs_n && bus1.adc_sclk)) idle_sclk++;
    end
    if (bus0.adc_cs_n === 1'b0) low0++;
    else begin
      if (low0 != 0) len0 = low0;
      low0 = 0;
    end
    if (bus1.adc_cs_n === 1'b0) low1++;
    else begin
      if (low1 != 0) len1 = low1;
      low1 = 0;
    end
    cs_prev = bus0.adc_cs_n;
    out_prev = bus0.adc_out;
  end

  int errors = 0, checks = 0;
  int ref_acc = 0, ref_n = 0, ref_out = 0;
  bit ref_first = 1'b0;
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference: mean of each group of four delivered samples, published when it clears the dead band
  task automatic ref_sample(input int v);
    int avg;
    ref_acc += v;
    ref_n++;
    if (ref_n == 4) begin
      avg = ref_acc / 4;
      ref_acc = 0;
      ref_n = 0;
      if (!ref_first || avg > ref_out + 2 || ref_out > avg + 2 || ((avg == 0 || avg == 1023) && avg != ref_out)) begin
        ref_first = 1'b1;
        ref_out = avg;
        exp_q.push_back(avg);
      end
    end
  endtask

  task automatic feed(input int v);
    next_vals.push_back(10'(v));
    ref_sample(v);
  endtask

  task automatic wait_frames(input int n, input string tag);
    int target = frames0 + n;
    int budget = n * 250 + 400;
    while (frames0 < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, " frames"}, frames0, target);
    repeat (4) @(negedge clk);
  endtask

  task automatic verify(input string tag);
    check({tag, " pulses"}, pub_q.size(), exp_q.size());
    while (pub_q.size() > 0 && exp_q.size() > 0) check({tag, " value"}, pub_q.pop_front(), exp_q.pop_front());
    pub_q.delete();
    exp_q.delete();
    check({tag, " adc_out"}, bus0.adc_out, ref_out);
  endtask

  task automatic group(input string tag, input int a, input int b, input int c, input int d);
    feed(a);
    feed(b);
    feed(c);
    feed(d);
    wait_frames(4, tag);
    verify(tag);
  endtask

  function automatic int clamp(input int x);
    return x < 0 ? 0 : x > 1023 ? 1023 : x;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("rst sclk", bus0.adc_sclk, 0);
    check("rst mosi", bus0.adc_mosi, 0);
    check("rst cs_n", bus0.adc_cs_n, 1);
    check("rst adc_out", bus0.adc_out, 0);
    check("rst valid", bus0.adc_valid, 0);
    check("rst busy", bus0.busy, 0);
    check("rst cs_n ch5", bus1.adc_cs_n, 1);
    feed(512); feed(512); feed(512); feed(512);
    rst = 1'b0;
    wait_frames(4, "const512");
    verify("const512");
    check("cmd ch0", cmd0, 5'b00011);
    check("cmd ch5", cmd1, 5'b10111);
    check("cs low ch0", len0, 74);
    check("cs low ch5", len1, 74);
    group("hyst hold", 512, 512, 513, 514);
    group("hyst step", 515, 515, 515, 515);
    group("hyst small", 516, 516, 516, 516);
    group("top end", 1023, 1023, 1023, 1023);
    group("near top", 1021, 1021, 1021, 1021);
    group("bottom end", 0, 0, 0, 0);
    group("bit order", 682, 341, 682, 341);
    for (int r = 0; r < 8; r++) begin
      int base;
      int v[4];
      base = (r % 2 == 1) ? ref_out + int'($urandom_range(0, 6)) - 3 : int'($urandom_range(0, 1023));
      for (int i = 0; i < 4; i++) v[i] = clamp(base + int'($urandom_range(0, 3)) - 1);
      group("random", v[0], v[1], v[2], v[3]);
    end
    next_vals.push_back(10'd300);
    for (int t = 0; t < 400 && k0 != 10; t++) @(negedge clk);
    check("reach k9", k0, 10);
    rst = 1'b1;
    @(negedge clk);
    check("abort cs_n", bus0.adc_cs_n, 1);
    check("abort sclk", bus0.adc_sclk, 0);
    check("abort busy", bus0.busy, 0);
    next_vals.delete();
    pub_q.delete();
    exp_q.delete();
    ref_acc = 0;
    ref_n = 0;
    ref_out = 0;
    ref_first = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    group("after abort", 300, 300, 300, 300);
    check("valid latency", lat_bad, 0);
    check("silent out change", glitch, 0);
    check("sclk idle", idle_sclk, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
